// File: rtl/eth_tx_framer.sv
// Byte-wide AXI-Stream Ethernet TX framer: forwards frames, pads, appends CRC-32 FCS, enforces IFG.
// Padding to MIN_FRAME_LEN is compiled in only when ETH_TX_PAD_EN is defined.
module eth_tx_framer #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_CYCLES    = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o
);

  if (MIN_FRAME_LEN < 1 || MIN_FRAME_LEN > 1500) begin : g_bad_min
    $error("MIN_FRAME_LEN must be 1..1500");
  end
  if (IFG_CYCLES < 0 || IFG_CYCLES > 255) begin : g_bad_ifg
    $error("IFG_CYCLES must be 0..255");
  end

  typedef enum logic [2:0] {
    IDLE, DATA, FCS, GAP
`ifdef ETH_TX_PAD_EN
    , PAD
`endif
  } state_t;

  localparam logic [7:0] LP_IFG_LAST = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t      r_state;
  logic [31:0] r_crc;
  logic [2:0]  r_fcs_idx;
  logic [7:0]  r_gap;
  logic        r_tuser_lat;
  logic [15:0] r_frame_cnt;
  logic [7:0]  r_m_tdata;
  logic        r_m_tvalid;
  logic        r_m_tlast;
  logic        r_m_tuser;

  logic        w_adv;
  logic        w_s_rdy;
  logic        w_s_acc;
  logic [31:0] w_crc_data;
  logic [7:0]  w_fcs_byte;

`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] LP_MIN = 11'(MIN_FRAME_LEN);
  logic [10:0] r_byte_cnt;
  logic [10:0] w_cnt_base;
  logic [10:0] w_cnt_nxt;
  logic [31:0] w_crc_pad;

  always_comb begin
    w_cnt_base = (r_state == IDLE) ? 11'd0 : r_byte_cnt;
    // Saturate at 2047 so oversize frames never wrap into a false "short" decision.
    w_cnt_nxt  = (w_cnt_base == 11'h7FF) ? w_cnt_base : w_cnt_base + 11'd1;
    w_crc_pad  = crc_byte(r_crc, 8'h00);
  end
`endif

  always_comb begin
    w_adv      = !r_m_tvalid || m_axis_tready;
    w_s_rdy    = !rst_i && (r_state == IDLE || r_state == DATA) && w_adv;
    w_s_acc    = w_s_rdy && s_axis_tvalid;
    w_crc_data = crc_byte((r_state == IDLE) ? 32'hFFFF_FFFF : r_crc, s_axis_tdata);
    w_fcs_byte = 8'h00;
    case (r_fcs_idx[1:0])
      2'd0:    w_fcs_byte = ~r_crc[7:0];
      2'd1:    w_fcs_byte = ~r_crc[15:8];
      2'd2:    w_fcs_byte = ~r_crc[23:16];
      default: w_fcs_byte = ~r_crc[31:24];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_crc       <= 32'hFFFF_FFFF;
      r_fcs_idx   <= 3'd0;
      r_gap       <= 8'd0;
      r_tuser_lat <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_m_tdata   <= 8'h00;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tuser   <= 1'b0;
`ifdef ETH_TX_PAD_EN
      r_byte_cnt  <= 11'd0;
`endif
    end else begin
      case (r_state)
        IDLE, DATA: begin
          if (w_s_acc) begin
            r_m_tdata  <= s_axis_tdata;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_crc      <= w_crc_data;
            r_state    <= DATA;
`ifdef ETH_TX_PAD_EN
            r_byte_cnt <= w_cnt_nxt;
`endif
            if (s_axis_tlast) begin
              r_tuser_lat <= s_axis_tuser;
              r_fcs_idx   <= 3'd0;
`ifdef ETH_TX_PAD_EN
              r_state     <= (w_cnt_nxt < LP_MIN) ? PAD : FCS;
`else
              r_state     <= FCS;
`endif
            end
          end else if (w_adv) begin
            r_m_tvalid <= 1'b0;
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: begin
          if (w_adv) begin
            r_m_tdata  <= 8'h00;
            r_m_tvalid <= 1'b1;
            r_crc      <= w_crc_pad;
            r_byte_cnt <= r_byte_cnt + 11'd1;
            if (r_byte_cnt + 11'd1 == LP_MIN) r_state <= FCS;
          end
        end
`endif
        FCS: begin
          // Index 4 means the final FCS byte is on the bus awaiting its handshake.
          if (r_fcs_idx == 3'd4) begin
            if (m_axis_tready) begin
              r_m_tvalid  <= 1'b0;
              r_m_tlast   <= 1'b0;
              r_m_tuser   <= 1'b0;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_gap       <= 8'd0;
              r_state     <= (IFG_CYCLES == 0) ? IDLE : GAP;
            end
          end else if (w_adv) begin
            r_m_tdata  <= w_fcs_byte;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= (r_fcs_idx == 3'd3);
            r_m_tuser  <= (r_fcs_idx == 3'd3) && r_tuser_lat;
            r_fcs_idx  <= r_fcs_idx + 3'd1;
          end
        end
        GAP: begin
          if (r_gap == LP_IFG_LAST) r_state <= IDLE;
          else                      r_gap   <= r_gap + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_tready = w_s_rdy;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign busy_o        = (r_state != IDLE);
  assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Randomized self-checking bench for eth_tx_framer against a frame-level reference model.
module tb_eth_tx_framer;
  localparam int MIN = 60;
  localparam int IFG = 12;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic        busy_o;
  logic [15:0] frame_cnt_o;

  eth_tx_framer #(.MIN_FRAME_LEN(MIN), .IFG_CYCLES(IFG)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
  );

  initial forever #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_frames = 0;
  bit          rnd_rdy = 1'b0;
  logic [9:0]  out_q[$];
  logic [9:0]  exp_q[$];
  logic [7:0]  b[$];
  int          runs[$];
  int          run = 0;
  int          stall_bad = 0;
  logic        stall_pend = 1'b0;
  logic [9:0]  stall_d = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC: bit-serial over the whole padded frame.
  function automatic logic [31:0] ref_crc(input logic [7:0] f[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (f[i])
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ f[i][j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return ~c;
  endfunction

  function automatic void model_push(input logic [7:0] p[$], input bit usr);
    logic [7:0]  f[$];
    logic [31:0] c;
    logic [9:0]  v;
    f = p;
`ifdef ETH_TX_PAD_EN
    while (f.size() < MIN) f.push_back(8'h00);
`endif
    c = ref_crc(f);
    foreach (f[i]) exp_q.push_back({2'b00, f[i]});
    for (int k = 0; k < 4; k++) begin
      v = {(k == 3) && usr, k == 3, c[8*k +: 8]};
      exp_q.push_back(v);
    end
    exp_frames++;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: sampled mid-cycle, records accepted beats, stall stability and idle runs.
  initial forever begin
    @(negedge clk);
    if (rst_i) begin
      run = 0;
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && (!m_axis_tvalid || {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== stall_d))
        stall_bad++;
      stall_pend = m_axis_tvalid && !m_axis_tready;
      stall_d    = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (m_axis_tvalid && m_axis_tready) out_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (!m_axis_tvalid && !s_axis_tready) run++;
      else if (run > 0) begin
        runs.push_back(run);
        run = 0;
      end
    end
  end

  task automatic send_beat();
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 3000) begin
      @(negedge clk); acc = s_axis_tready;
      @(posedge clk); #1;
      t++;
    end
    if (!acc) chk("src_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input bit usr, input int gap_pct);
    model_push(p, usr);
    for (int i = 0; i < p.size(); i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = p[i];
      s_axis_tlast  = (i == p.size() - 1);
      s_axis_tuser  = (i == p.size() - 1) ? usr : 1'($urandom_range(0, 1));
      send_beat();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_cmp(input string tag);
    int t = 0;
    while (out_q.size() < exp_q.size() && t < 8000) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    chk({tag, "_len"}, out_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      chk({tag, "_beat"}, 32'(out_q[i]), 32'(exp_q[i]));
      if (out_q[i] !== exp_q[i]) break;
    end
    chk({tag, "_frame_cnt"}, 32'(frame_cnt_o), 32'(exp_frames[15:0]));
  endtask

  task automatic clr();
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic rnd_frame(input int len);
    b.delete();
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_s_tready"}, 32'(s_axis_tready), 32'd0);
    chk({tag, "_m_tvalid"}, 32'(m_axis_tvalid), 32'd0);
    chk({tag, "_m_tlast"},  32'(m_axis_tlast),  32'd0);
    chk({tag, "_m_tuser"},  32'(m_axis_tuser),  32'd0);
    chk({tag, "_m_tdata"},  32'(m_axis_tdata),  32'd0);
    chk({tag, "_busy"},     32'(busy_o),        32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt_o),  32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Known-answer frame "123456789".
    clr();
    b.delete();
    for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
    send_frame(b, 1'b0, 0);
    wait_cmp("kat");
`ifdef ETH_TX_PAD_EN
    chk("kat_pad_len", out_q.size(), 32'd64);
`else
    if (out_q.size() >= 13) begin
      chk("kat_fcs", {out_q[12][7:0], out_q[11][7:0], out_q[10][7:0], out_q[9][7:0]}, 32'hCBF4_3926);
      chk("kat_tlast", 32'(out_q[12][8]), 32'd1);
    end else chk("kat_short", out_q.size(), 32'd13);
`endif

    // Exactly-minimum frame 0x00..0x3B: no padding either way.
    clr();
    b.delete();
    for (int i = 0; i < 60; i++) b.push_back(8'(i));
    send_frame(b, 1'b0, 0);
    wait_cmp("min60");
    chk("min60_len", out_q.size(), 32'd64);

    // 100-byte frame, then the same bytes again under 50% backpressure.
    rnd_frame(100);
    clr();
    send_frame(b, 1'b0, 0);
    wait_cmp("f100_rdy");
    clr();
    rnd_rdy = 1'b1;
    send_frame(b, 1'b0, 0);
    wait_cmp("f100_stall");
    rnd_rdy = 1'b0;

    // Back-to-back 64-byte frames: inter-frame gap length.
    repeat (20) @(posedge clk); #1;
    runs.delete();
    clr();
    rnd_frame(64);
    send_frame(b, 1'b0, 0);
    rnd_frame(64);
    send_frame(b, 1'b0, 0);
    wait_cmp("b2b");
    repeat (20) @(posedge clk); #1;
    chk("b2b_gap_runs", runs.size(), 32'd2);
    if (runs.size() >= 2) begin
      chk("b2b_gap0", runs[0], IFG);
      chk("b2b_gap1", runs[1], IFG);
    end

    // Errored frame, then reset mid-way through the next one.
    clr();
    rnd_frame(20);
    send_frame(b, 1'b1, 0);
    wait_cmp("tuser");
    for (int i = 0; i < 10; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'($urandom);
      s_axis_tlast  = 1'b0;
      send_beat();
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_outs("midrst");
    s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_i = 1'b0;
    clr();
    exp_frames = 0;
    rnd_frame(30);
    send_frame(b, 1'b0, 0);
    wait_cmp("post_rst");

    // Randomized frames with source gaps, backpressure and tuser; includes a 1-byte frame.
    clr();
    rnd_rdy = 1'b1;
    rnd_frame(1);
    send_frame(b, 1'($urandom_range(0, 1)), 20);
    for (int f = 0; f < 6; f++) begin
      rnd_frame($urandom_range(1, 130));
      send_frame(b, 1'($urandom_range(0, 1)), 20);
    end
    wait_cmp("rand");
    rnd_rdy = 1'b0;

    chk("stall_stable", stall_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
